muldiv_unit: RTL
================

# muldiv_unit

Parametrised multicycle RV32M multiply/divide unit for the EX stage of the five-stage pipeline. It executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU on operands that have already been forwarded, and drives a stall to hold IF/ID/EX/MEM while it runs. The unit also accepts a flush so that work on a mispredicted path can be cancelled.

## Interface
- XLEN, 32: operand and result width; must be even and at least 8.
- FAST_MUL, 1: 1 = multiply result in a single cycle (one-shot XLEN×XLEN product); 0 = iterative shift-add over XLEN cycles.

- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  ID_EX holds a valid M-extension instruction.
- flush  in  1  cancels any in-flight or requested operation.
- funct3  in  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- A  in  XLEN  rs1 operand (forwarded).
- B  in  XLEN  rs2 operand (forwarded).
- busy  out  1  an operation is in progress (state MUL or DIV).
- done  out  1  single-cycle pulse; `result` is valid in this cycle.
- stall  out  1  holds the pipeline registers and PC.
- result  out  XLEN  last completed result; holds until the next done.

## Operation
- States:
  - IDLE: no operation.
  - MUL: iterative multiply.
  - DIV: iterative divide.
  - DONE: result presented.
- IDLE, start=1, flush=0: latch funct3, A, B and the sign flags.
  - Next state is DONE when the op is a multiply and FAST_MUL=1.
  - Next state is DONE when the op is a divide/remainder with B=0 (divide by zero).
  - Next state is DONE when the op is DIV or REM with A=100…0 and B=all ones (signed overflow).
  - Next state is MUL for a multiply with FAST_MUL=0.
  - Next state is DIV for all other divide/remainder ops.
- MUL: shift-add over magnitudes, one bit per cycle, 2·XLEN-bit accumulator. After XLEN iterations the product is sign-corrected and the state goes to DONE.
- DIV: restoring divide over |A| and |B|, one quotient bit per cycle. After XLEN iterations the quotient and remainder are sign-corrected and the state goes to DONE.
- Sign rules:
  - MULH treats A and B as signed.
  - MULHSU treats A as signed and B as unsigned.
  - MULHU treats both as unsigned.
  - Quotient is negative iff the operand signs differ. Remainder takes the sign of A. Both apply only for signed ops.
- Result selection:
  - MUL gives product[XLEN-1:0]; MULH, MULHSU and MULHU give product[2XLEN-1:XLEN].
  - Divide by zero: quotient = all ones for both signed and unsigned; remainder = A.
  - Signed overflow: quotient = A; remainder = 0.
- DONE: done=1 and `result` is registered. `start` is ignored in this state (it is the same instruction), and the state returns to IDLE.
- stall = (IDLE & start & ~flush) | busy. stall is 0 in DONE so the pipeline advances on that edge.
- busy = state is MUL or DIV.
- flush has priority over everything except reset. In any state the next state is IDLE, no done is produced and `result` is unchanged. In IDLE with start, the request is not accepted.
- Reset: state=IDLE, busy=0, done=0, stall=0 (start is masked while rstn=0), result=0, internal registers=0. Reset mid-operation discards the operation.

## Timing
- Cycle 0 is the IDLE cycle in which start is accepted.
- Fast multiply, divide by zero, signed overflow: DONE in cycle 1 (latency 1); stall high in cycle 0 only.
- Iterative multiply and divide: cycles 1..XLEN in MUL or DIV; DONE in cycle XLEN+1. stall is high in cycles 0..XLEN (XLEN+1 cycles).
- A and B are sampled only in cycle 0; later changes have no effect.
- Back-to-back ops: the next start is accepted in the cycle after DONE, with no idle bubble required.
- flush in cycle k: IDLE in cycle k+1, stall=0 from cycle k if IDLE or k+1 otherwise.

## Test plan
- MUL (FAST_MUL=1), A=7, B=0xFFFFFFFD (−3) → done in cycle 1, result 0xFFFFFFEB; stall high in cycle 0 only.
- High products:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - Repeat all three with FAST_MUL=0 and check done in cycle 33.
- Signed divide:
  - DIV −7/2 → 0xFFFFFFFD, done in cycle 33, stall high in cycles 0..32, busy high in 1..32.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Corner cases:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
  - All four complete with done in cycle 1.
- DIV started with flush pulsed in cycle 10 → IDLE and stall=0 in cycle 11, no done, result unchanged. A new MUL started in cycle 11 completes normally.
- rstn pulled low in cycle 5 of a DIV → asynchronously busy=0, done=0, result=0. After release, a start in the first clock gives a correct full-latency result.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multicycle RV32M multiply/divide unit for the EX stage.
// Multiplies run either as a one-shot product (FAST_MUL=1) or as a
// shift-add over XLEN cycles. Divides are always restoring, one quotient
// bit per cycle. Both paths work on operand magnitudes, and the sign is
// fixed up once, on the final step. While the unit works, stall holds the
// front of the pipeline.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [XLEN-1:0]     r_result;
  logic [2:0]          r_f3;
  logic [2*XLEN-1:0]   r_acc;    // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]     r_opb;    // mul: multiplicand magnitude; div: divisor magnitude
  logic                r_neg_lo; // product or quotient must be negated
  logic                r_neg_hi; // remainder must be negated
  logic [CW-1:0]       r_cnt;

  // Two's-complement negate when requested (XLEN wide)
  function automatic logic [XLEN-1:0] f_cneg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Two's-complement negate when requested (2*XLEN wide)
  function automatic logic [2*XLEN-1:0] f_cneg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // MUL takes the low half, every MULH* variant the high half
  function automatic logic [XLEN-1:0] f_sel_mul(input logic [2*XLEN-1:0] p, input logic [2:0] f3);
    return (f3 == 3'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Operand decode
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div0;
  logic            w_ovf;
  logic            w_fast;

  assign w_is_div   = funct3[2];
  assign w_a_signed = w_is_div ? ~funct3[0] : ((funct3 == 3'd1) | (funct3 == 3'd2));
  assign w_b_signed = w_is_div ? ~funct3[0] : (funct3 == 3'd1);
  assign w_a_neg    = w_a_signed & A[XLEN-1];
  assign w_b_neg    = w_b_signed & B[XLEN-1];
  assign w_mag_a    = f_cneg(A, w_a_neg);
  assign w_mag_b    = f_cneg(B, w_b_neg);
  assign w_div0     = w_is_div & (B == '0);
  assign w_ovf      = w_is_div & ~funct3[0] & (A == MIN_NEG) & (B == '1);
  assign w_fast     = ~w_is_div & FAST_MUL;

  // One-shot product and the results that finish straight from IDLE
  logic [2*XLEN-1:0] w_mag_prod;
  logic [XLEN-1:0]   w_idle_res;

  assign w_mag_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
  assign w_idle_res = w_div0 ? (funct3[1] ? A : '1) :
                      w_ovf  ? (funct3[1] ? '0 : A) :
                      f_sel_mul(f_cneg2(w_mag_prod, w_a_neg ^ w_b_neg), funct3);

  // Shift-add step: conditionally add the multiplicand to the top half, then shift right
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN-1:0]   w_mul_res;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_mul_res  = f_sel_mul(f_cneg2(w_mul_next, r_neg_lo), r_f3);

  // Restoring step: the remainder is always below the divisor, so the sign of the
  // difference alone says whether the shifted remainder can be reduced
  logic [XLEN:0]     w_div_sh;
  logic [XLEN:0]     w_div_diff;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_rem;
  logic [2*XLEN-1:0] w_div_next;
  logic [XLEN-1:0]   w_div_res;

  assign w_div_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_opb};
  assign w_div_ge   = ~w_div_diff[XLEN];
  assign w_div_rem  = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_sh[XLEN-1:0];
  assign w_div_next = {w_div_rem, r_acc[XLEN-2:0], w_div_ge};
  assign w_div_res  = r_f3[1] ? f_cneg(w_div_next[2*XLEN-1:XLEN], r_neg_hi)
                              : f_cneg(w_div_next[XLEN-1:0], r_neg_lo);

  logic w_last;
  assign w_last = (r_cnt == CW'(XLEN - 1));

  // Control FSM and datapath: latch in IDLE, iterate in MUL/DIV, publish the result on entry to DONE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_f3     <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_f3     <= funct3;
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_a_neg;
            r_cnt    <= '0;
            if (w_is_div) begin
              r_acc <= {{XLEN{1'b0}}, w_mag_a};
              r_opb <= w_mag_b;
            end else begin
              r_acc <= {{XLEN{1'b0}}, w_mag_b};
              r_opb <= w_mag_a;
            end
            if (w_fast | w_div0 | w_ovf) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_idle_res;
            end else if (w_is_div) begin
              r_state <= S_DIV;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_MUL;
              r_busy  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_mul_res;
          end
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_div_res;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign stall  = rstn & (((r_state == S_IDLE) & start & ~flush) | r_busy);

endmodule
